load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle RV32I core's data-memory port.
- Converts each LOAD/STORE request into a word-aligned transaction on a valid/ready memory bus, with byte-lane steering and write strobes.
- On loads, extracts the addressed byte/half/word and sign- or zero-extends it.
- Holds the core with `stall` until the access completes, and reports misaligned, bad-size and timeout faults.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before the access is aborted with a timeout fault. Legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- req_rd  in  1  core load request
- req_wr  in  1  core store request
- req_addr  in  32  byte address (word_t)
- req_size  in  3  funct3 (mem_addr_t): 0 B, 1 H, 2 W, 4 BU, 5 HU
- req_wdata  in  32  store data; low bits are significant
- stall  out  1  core must hold its request and PC while high
- done  out  1  one-cycle pulse: access complete
- rdata  out  32  extended load result; valid while `done` is high
- err  out  1  one-cycle pulse: fault
- err_cause  out  2  fault cause: 1 misaligned, 2 bad size, 3 timeout; 0 otherwise
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts the request
- bus_we  out  1  write enable
- bus_addr  out  32  word address, bits [1:0] always 0
- bus_wstrb  out  4  byte write strobes
- bus_wdata  out  32  lane-replicated store data
- bus_rvalid  in  1  read response valid
- bus_rdata  in  32  read response data

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (rst==0 at a clock edge): state IDLE, timeout counter 0, every registered output 0. Reset mid-access drops `bus_valid` on the next cycle. A later `bus_rvalid` is ignored.

IDLE
- A request is any cycle with `req_rd|req_wr`. If both are set, the access is a load and `req_wr` is ignored.
- Fault checks are combinational in IDLE:
  - Bad size: a load with size in {3,6,7}, or a store with size >2.
  - Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
  - Bad size takes priority over misaligned.
- On a fault: `err`=1 with its cause, `stall`=0, `rdata`=0, no bus activity, stay in IDLE.
- Otherwise `stall`=1 in the same cycle. Latch addr, size, we, wstrb and wdata, then go to REQ.

REQ
- `bus_valid`=1, and all bus outputs are held stable until the handshake.
- On `bus_valid & bus_ready`: a store goes to DONE; a load goes to WAIT.

WAIT
- `bus_rvalid` is sampled only in WAIT, so the earliest response is the cycle after the handshake.
- On `rvalid`, capture the extended data and go to DONE.

DONE
- `stall`=0 and `done`=1 for exactly one cycle, then IDLE.
- Requests seen in DONE belong to the completing instruction and are ignored.

Timeout
- The counter clears on entering REQ and increments each cycle in REQ/WAIT.
- When it reaches TIMEOUT_CYCLES: go to DONE with `err`=1, cause 3, `rdata`=0, and `bus_valid` dropped.
- If `rvalid` or the handshake arrives in the same cycle the counter reaches TIMEOUT_CYCLES, completion wins.

`stall`
- High in IDLE on a legal request, and in REQ and WAIT. Low otherwise.

Lane rules (o = addr[1:0])
- Store byte: wdata = {4{d[7:0]}}, wstrb = 4'b0001<<o.
- Store half: wdata = {2{d[15:0]}}, wstrb = o[1] ? 4'b1100 : 4'b0011.
- Store word: wdata = d, wstrb = 4'b1111.
- Load: x = bus_rdata >> (8*o). B sign-extends x[7:0], BU zero-extends x[7:0], H and HU do the same with x[15:0], W returns x.
- Loads drive `bus_wstrb`=0 and `bus_wdata`=0.

Latency
- Store with `ready` in the first REQ cycle: `done` 2 cycles after the request appears.
- Load with `ready` immediate and `rvalid` the next cycle: `done` 3 cycles after the request appears.

Decomposition:
- Shared package, next to word_t and mem_addr_t:
  - lsu_state_t enum
  - lsu_err_t enum (NONE, MISALIGN, BADSIZE, TIMEOUT)
  - size constants SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU
  - functions lsu_wstrb(size, off) and lsu_misaligned(size, off)
- One combinational sub-module, lsu_align: store lane replication, strobe generation, load shift and extension. The FSM and counter stay in load_store_unit.

Test Plan:
- SB addr 0x103, wdata 0x000000A5, `ready` immediate -> `bus_addr` 0x100, `wstrb` 0x8, `wdata` 0xA5A5A5A5, `done` 2 cycles after the request, `stall` high 2 cycles.
- LH addr 0x202, `bus_rdata` 0x8001_1234, `rvalid` 1 cycle after the handshake -> `rdata` 0xFFFF8001. The same access as LHU -> 0x00008001.
- LW addr 0x301 -> `err`=1, cause 1, `stall`=0, `bus_valid` never asserted. Load size 3 at 0x300 -> cause 2.
- LB with `bus_ready` held low 4 cycles -> `bus_valid` and `bus_addr` stable for 5 cycles, then WAIT. `rvalid` with 0x11223344 at addr offset 1 -> `rdata` 0x00000033.
- TIMEOUT_CYCLES=8, load, `rvalid` never returned -> `done`+`err`, cause 3, `rdata`=0, exactly 8 cycles after entering REQ. A repeat with `rvalid` on the 8th cycle -> normal completion, no error.
- rst=0 during WAIT, then a late `rvalid` -> state IDLE, `done` never pulses. A following SW at 0x400 proceeds normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types, size codes and lane helpers for the load/store unit.
// Pure declarations; no state.
// Consumed by the LSU top, its align sub-block and the bus interface.
package load_store_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  mem_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BADSIZE  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } lsu_err_t;

  localparam mem_addr_t SZ_B  = 3'd0;
  localparam mem_addr_t SZ_H  = 3'd1;
  localparam mem_addr_t SZ_W  = 3'd2;
  localparam mem_addr_t SZ_BU = 3'd4;
  localparam mem_addr_t SZ_HU = 3'd5;

  // Byte-lane write strobes for an access of the given size at byte offset off.
  function automatic logic [3:0] lsu_wstrb(mem_addr_t size, logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      SZ_B, SZ_BU: s = 4'b0001 << off;
      SZ_H, SZ_HU: s = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:        s = 4'b1111;
      default:     s = 4'b0000;
    endcase
    return s;
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic lsu_misaligned(mem_addr_t size, logic [1:0] off);
    logic m;
    m = 1'b0;
    case (size)
      SZ_H, SZ_HU: m = off[0];
      SZ_W:        m = (off != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned valid/ready memory bus between the LSU and data memory.
// Request phase held until valid&ready; read data returns later on rvalid.
// master = LSU side, slave = memory side.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  word_t       bus_addr;
  logic [3:0]  bus_wstrb;
  word_t       bus_wdata;
  logic        bus_rvalid;
  word_t       bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication/strobes and load shift/extension.
// Purely combinational, zero latency.
// No flow control; callers qualify the results.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  mem_addr_t  i_st_size,
  input  logic [1:0] i_st_off,
  input  logic       i_st_we,
  input  word_t      i_st_data,
  output logic [3:0] o_wstrb,
  output word_t      o_wdata,
  input  mem_addr_t  i_ld_size,
  input  logic [1:0] i_ld_off,
  input  word_t      i_rdata,
  output word_t      o_ld_data
);

  word_t w_x;

  // Store path: replicate the low bytes across every lane; loads drive zeros.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = '0;
    if (i_st_we) begin
      o_wstrb = lsu_wstrb(i_st_size, i_st_off);
      case (i_st_size)
        SZ_B:    o_wdata = {4{i_st_data[7:0]}};
        SZ_H:    o_wdata = {2{i_st_data[15:0]}};
        default: o_wdata = i_st_data;
      endcase
    end
  end

  // Load path: shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    w_x       = i_rdata >> {i_ld_off, 3'b000};
    o_ld_data = w_x;
    case (i_ld_size)
      SZ_B:    o_ld_data = {{24{w_x[7]}}, w_x[7:0]};
      SZ_BU:   o_ld_data = {24'd0, w_x[7:0]};
      SZ_H:    o_ld_data = {{16{w_x[15]}}, w_x[15:0]};
      SZ_HU:   o_ld_data = {16'd0, w_x[15:0]};
      default: o_ld_data = w_x;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core data-port to valid/ready bus bridge with fault and timeout detection.
// Store: done 2 cycles after request; load: 3 cycles minimum.
// Core stalled while the access is outstanding; bus request held until ready.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_rd,
  input  logic       i_req_wr,
  input  word_t      i_req_addr,
  input  mem_addr_t  i_req_size,
  input  word_t      i_req_wdata,
  output logic       o_stall,
  output logic       o_done,
  output word_t      o_rdata,
  output logic       o_err,
  output logic [1:0] o_err_cause,
  load_store_unit_if.master bus
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

  lsu_state_t  r_state, w_state_nxt;
  word_t       r_addr;
  mem_addr_t   r_size;
  logic        r_we;
  logic [3:0]  r_wstrb;
  word_t       r_wdata;
  word_t       r_rdata;
  logic        r_to;
  logic [15:0] r_cnt;

  logic        w_req, w_is_store, w_badsize, w_misalign;
  logic        w_accept, w_capture, w_timeout, w_cnt_hit;
  logic [15:0] w_cnt_nxt;
  logic [3:0]  w_st_strb;
  word_t       w_st_data, w_ld_data;

  // A load wins when both strobes are set; nothing is accepted while in reset.
  assign w_req      = (i_req_rd | i_req_wr) & rst;
  assign w_is_store = ~i_req_rd & i_req_wr;
  assign w_badsize  = i_req_rd ? (i_req_size == 3'd3 || i_req_size == 3'd6 || i_req_size == 3'd7)
                               : (i_req_size > SZ_W);
  assign w_misalign = lsu_misaligned(i_req_size, i_req_addr[1:0]);
  assign w_cnt_nxt  = r_cnt + 16'd1;
  assign w_cnt_hit  = (w_cnt_nxt == LP_TIMEOUT);

  lsu_align u_align (
    .i_st_size (i_req_size),
    .i_st_off  (i_req_addr[1:0]),
    .i_st_we   (w_is_store),
    .i_st_data (i_req_wdata),
    .o_wstrb   (w_st_strb),
    .o_wdata   (w_st_data),
    .i_ld_size (r_size),
    .i_ld_off  (r_addr[1:0]),
    .i_rdata   (bus.bus_rdata),
    .o_ld_data (w_ld_data)
  );

  assign bus.bus_valid = (r_state == ST_REQ);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = {r_addr[31:2], 2'b00};
  assign bus.bus_wstrb = r_wstrb;
  assign bus.bus_wdata = r_wdata;

  // Next state and core-facing outputs; a completion event beats a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    o_stall     = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_err_cause = ERR_NONE;
    o_rdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_badsize) begin
            o_err       = 1'b1;
            o_err_cause = ERR_BADSIZE;
          end else if (w_misalign) begin
            o_err       = 1'b1;
            o_err_cause = ERR_MISALIGN;
          end else begin
            o_stall     = 1'b1;
            w_accept    = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        o_stall = 1'b1;
        if (bus.bus_ready) begin
          w_state_nxt = r_we ? ST_DONE : ST_WAIT;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_WAIT: begin
        o_stall = 1'b1;
        if (bus.bus_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        o_done      = 1'b1;
        o_rdata     = r_rdata;
        o_err       = r_to;
        o_err_cause = r_to ? ERR_TIMEOUT : ERR_NONE;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Request latch, timeout counter and load result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_wstrb <= 4'b0000;
      r_wdata <= '0;
      r_rdata <= '0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_size  <= i_req_size;
        r_we    <= w_is_store;
        r_wstrb <= w_st_strb;
        r_wdata <= w_st_data;
        r_rdata <= '0;
        r_to    <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
        r_cnt <= w_cnt_nxt;
      end
      if (w_capture) r_rdata <= w_ld_data;
      if (w_timeout) begin
        r_to    <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of the LSU against an arithmetic reference model.
// Timeout configured to 8 cycles; bus latencies drawn so accesses finish inside it.
// Memory side is driven directly through the interface instance.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic [1:0]  err_cause;
  int          n_checks = 0;
  int          n_fail   = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_rd    (req_rd),
    .i_req_wr    (req_wr),
    .i_req_addr  (req_addr),
    .i_req_size  (req_size),
    .i_req_wdata (req_wdata),
    .o_stall     (stall),
    .o_done      (done),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_err_cause (err_cause),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: fault cause from the access rules.
  function automatic int exp_cause(logic rd, logic [2:0] sz, logic [31:0] addr);
    int nb;
    if (rd ? (sz == 3'd3 || sz >= 3'd6) : (sz > 3'd2)) return 2;
    nb = 1 << (sz % 4);
    if (addr % nb != 0) return 1;
    return 0;
  endfunction

  // Reference: extended load value.
  function automatic logic [31:0] exp_load(logic [2:0] sz, logic [1:0] off, logic [31:0] d);
    logic [63:0] v, mask;
    int nb;
    nb   = 1 << (sz % 4);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = ({32'd0, d} >> (8 * off)) & mask;
    if (sz < 3'd4 && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Full access: request, REQ with rdy wait cycles, WAIT with rv cycles, DONE.
  task automatic access(input logic rd, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy, input int rv, input logic [31:0] rdat);
    int          cause, nb;
    logic [31:0] e_strb, e_wd, mask;
    cause = exp_cause(rd, sz, addr);
    nb    = 1 << (sz % 4);
    mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    e_strb = 32'd0;
    e_wd   = 32'd0;
    if (!rd) begin
      e_strb = ((32'd1 << nb) - 32'd1) << addr[1:0];
      for (int i = 0; i < 4 / nb; i++) e_wd = e_wd | ((wd & mask) << (8 * nb * i));
    end
    req_rd = rd; req_wr = wr; req_size = sz; req_addr = addr; req_wdata = wd;
    #3;
    if (cause != 0) begin
      chk("fault_err", 32'(err), 32'd1);
      chk("fault_cause", 32'(err_cause), 32'(cause));
      chk("fault_stall", 32'(stall), 32'd0);
      chk("fault_rdata", rdata, 32'd0);
      req_rd = 1'b0; req_wr = 1'b0;
      tick();
      chk("fault_no_valid", 32'(bus_if.bus_valid), 32'd0);
      return;
    end
    chk("req_stall", 32'(stall), 32'd1);
    chk("req_no_err", 32'(err), 32'd0);
    tick();
    for (int k = 0; k <= rdy; k++) begin
      bus_if.bus_ready = (k == rdy);
      #3;
      chk("bus_valid", 32'(bus_if.bus_valid), 32'd1);
      chk("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
      chk("bus_we", 32'(bus_if.bus_we), 32'(!rd));
      chk("bus_wstrb", 32'(bus_if.bus_wstrb), e_strb);
      chk("bus_wdata", bus_if.bus_wdata, e_wd);
      chk("req_phase_stall", 32'(stall), 32'd1);
      tick();
    end
    bus_if.bus_ready = 1'b0;
    if (rd) begin
      for (int k = 0; k <= rv; k++) begin
        bus_if.bus_rvalid = (k == rv);
        bus_if.bus_rdata  = (k == rv) ? rdat : $urandom;
        #3;
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_valid_low", 32'(bus_if.bus_valid), 32'd0);
        chk("wait_no_done", 32'(done), 32'd0);
        tick();
      end
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = $urandom;
    end
    #3;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_err", 32'(err), 32'd0);
    chk("done_rdata", rdata, rd ? exp_load(sz, addr[1:0], rdat) : 32'd0);
    req_rd = 1'b0; req_wr = 1'b0;
    tick();
    #3;
    chk("after_done", 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rw, rd_v;
    int          kind;
    rst = 1'b0;
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    tick();
    tick();
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cause", 32'(err_cause), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("rst_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    rst = 1'b1;
    tick();

    // SB, LH, LHU, faults, slow-ready LB
    access(1'b0, 1'b1, SZ_B, 32'h103, 32'h0000_00A5, 0, 0, 32'd0);
    access(1'b1, 1'b0, SZ_H, 32'h202, 32'd0, 0, 0, 32'h8001_1234);
    access(1'b1, 1'b0, SZ_HU, 32'h202, 32'd0, 0, 0, 32'h8001_1234);
    access(1'b1, 1'b0, SZ_W, 32'h301, 32'd0, 0, 0, 32'd0);
    access(1'b1, 1'b0, 3'd3, 32'h300, 32'd0, 0, 0, 32'd0);
    access(1'b0, 1'b1, 3'd4, 32'h300, 32'd0, 0, 0, 32'd0);
    access(1'b0, 1'b1, SZ_H, 32'h301, 32'd0, 0, 0, 32'd0);
    access(1'b1, 1'b0, SZ_B, 32'h101, 32'd0, 4, 0, 32'h1122_3344);
    access(1'b1, 1'b1, SZ_W, 32'h104, 32'hDEAD_BEEF, 1, 2, 32'hCAFE_F00D);
    access(1'b0, 1'b1, SZ_H, 32'h106, 32'h0000_BEEF, 2, 0, 32'd0);

    // Load with no response: timeout exactly 8 cycles after entering REQ
    req_rd = 1'b1; req_wr = 1'b0; req_size = SZ_W; req_addr = 32'h500;
    #3;
    chk("to_req_stall", 32'(stall), 32'd1);
    tick();
    bus_if.bus_ready = 1'b1;
    #3;
    chk("to_valid", 32'(bus_if.bus_valid), 32'd1);
    tick();
    bus_if.bus_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #3;
      chk("to_wait_stall", 32'(stall), 32'd1);
      chk("to_wait_done", 32'(done), 32'd0);
      tick();
    end
    #3;
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_cause", 32'(err_cause), 32'd3);
    chk("to_rdata", rdata, 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_valid_low", 32'(bus_if.bus_valid), 32'd0);
    req_rd = 1'b0;
    tick();
    #3;
    chk("to_err_clear", 32'(err), 32'd0);
    // Response on the 8th cycle completes normally
    access(1'b1, 1'b0, SZ_W, 32'h500, 32'd0, 0, 6, 32'h1357_9BDF);

    // Reset during WAIT, then a late response is ignored
    req_rd = 1'b1; req_wr = 1'b0; req_size = SZ_W; req_addr = 32'h600;
    tick();
    bus_if.bus_ready = 1'b1;
    tick();
    bus_if.bus_ready = 1'b0;
    #3;
    chk("rw_wait_stall", 32'(stall), 32'd1);
    req_rd = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #3;
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_valid", 32'(bus_if.bus_valid), 32'd0);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hAAAA_5555;
    tick();
    bus_if.bus_rvalid = 1'b0;
    #3;
    chk("rw_late_done", 32'(done), 32'd0);
    chk("rw_late_err", 32'(err), 32'd0);
    tick();
    #3;
    chk("rw_late_done2", 32'(done), 32'd0);
    access(1'b0, 1'b1, SZ_W, 32'h400, 32'h0BAD_F00D, 0, 0, 32'd0);

    // Randomized accesses within the timeout budget
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      ra   = $urandom;
      rw   = $urandom;
      rd_v = $urandom;
      access(kind != 1, kind != 0, 3'($urandom_range(0, 7)), ra, rw,
             $urandom_range(0, 3), $urandom_range(0, 3), rd_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
